tick_gen: RTL and testbench

Multi-channel, runtime-reprogrammable tick generator, the parametrised successor to the single fixed 50 MHz→1 Hz divider. Produces NUM_CH independent single-cycle tick enables (seconds, blink, display scan) and optional 50 %-ish square waves from one system clock. All clock-domain logic downstream uses the ticks as enables, never as clocks.

---
 rtl/tick_gen_pkg.sv | 17 +
 rtl/tick_gen_if.sv | 13 +
 rtl/tick_gen_ch.sv | 42 ++++
 rtl/tick_gen.sv | 53 +++++
 tb/tb_tick_gen.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared clock constants, divisor type and helpers for the tick generator
// Contents: CLK_HZ, CNT_W_DEF, DIV_1HZ/DIV_2HZ/DIV_1KHZ, div_t, ch_w(), pack_div3()
package tick_gen_pkg;
  localparam int CLK_HZ    = 50_000_000;
  localparam int CNT_W_DEF = 26;
  localparam int DIV_1HZ   = CLK_HZ;
  localparam int DIV_2HZ   = CLK_HZ / 2;
  localparam int DIV_1KHZ  = CLK_HZ / 1000;
  typedef logic [CNT_W_DEF-1:0] div_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // channel 0 lands in the low bits
  function automatic logic [3*CNT_W_DEF-1:0] pack_div3(input int d0, input int d1, input int d2);
    return {div_t'(d2), div_t'(d1), div_t'(d0)};
  endfunction
endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: divisor-load handshake between a configuring master and tick_gen
// Signals: cfg_valid/cfg_ch/cfg_div (master->slave), cfg_ready/cfg_err (slave->master)
interface tick_gen_if import tick_gen_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF
) ();
  localparam int CH_W = ch_w(NUM_CH);
  logic             cfg_valid, cfg_ready, cfg_err;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one divider channel, counter + divisor register + registered tick/square
// Ports: clk, reset (sync, active-high), en, sync, apply (load new_div), new_div,
//        wrap (comb: this edge ends the period), tick, sq (0 unless TICK_GEN_SQ_EN)
module tick_gen_ch import tick_gen_pkg::*; #(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk, reset, en, sync, apply,
  input  logic [CNT_W-1:0] new_div,
  output logic             wrap, tick, sq
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic             tick_q, tick_d;
  // >= keeps the counter bounded if a smaller divisor landed while frozen
  assign wrap = en && !sync && cnt_q >= div_q - CNT_W'(1);
  always_comb begin
    div_d  = apply ? new_div : div_q;
    cnt_d  = sync || wrap ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    tick_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
`ifdef TICK_GEN_SQ_EN
  logic sq_q, sq_d;
  // high from the tick cycle for div>>1 cycles; stays low until the first wrap
  always_comb sq_d = sync ? 1'b0 : wrap ? (div_d >> 1) != '0 : sq_q && cnt_d < (div_d >> 1);
  always_ff @(posedge clk) sq_q <= reset ? 1'b0 : sq_d;
  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif
endmodule

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH runtime-reprogrammable tick-enable generator with one-deep divisor load
// Ports: clk, reset (sync, active-high), en (global run), sync (phase restart),
//        cfg (tick_gen_if.slave load handshake), tick[NUM_CH], sq[NUM_CH]
// Build option: define TICK_GEN_SQ_EN to compile in the per-channel square waves
module tick_gen import tick_gen_pkg::*; #(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = pack_div3(DIV_1KHZ, DIV_2HZ, DIV_1HZ)
) (
  input  logic              clk, reset, en, sync,
  tick_gen_if.slave         cfg,
  output logic [NUM_CH-1:0] tick, sq
);
  localparam int CH_W = ch_w(NUM_CH);
  logic              pend_q, pend_d, cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d, hs, bad;
  logic [CH_W-1:0]   pch_q, pch_d;
  logic [CNT_W-1:0]  pdiv_q, pdiv_d;
  logic [NUM_CH-1:0] wrap, apply;
  always_comb begin
    hs          = cfg.cfg_valid && cfg_ready_q;
    bad         = cfg.cfg_div == '0 || 32'(cfg.cfg_ch) >= NUM_CH;
    pend_d      = hs && !bad ? 1'b1 : |apply ? 1'b0 : pend_q;
    pch_d       = hs && !bad ? cfg.cfg_ch : pch_q;
    pdiv_d      = hs && !bad ? cfg.cfg_div : pdiv_q;
    cfg_ready_d = !pend_d;
    cfg_err_d   = hs && bad;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pch_q       <= '0;
      pdiv_q      <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pch_q       <= pch_d;
      pdiv_q      <= pdiv_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.cfg_err   = cfg_err_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // a pending divisor lands at its channel's wrap, or at once when frozen or re-phased
    assign apply[i] = pend_q && pch_q == CH_W'(i) && (sync || !en || wrap[i]);
    tick_gen_ch #(.CNT_W(CNT_W), .DIV_RST(DIV_INIT[i*CNT_W +: CNT_W])) u_ch (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .apply(apply[i]),
      .new_div(pdiv_q), .wrap(wrap[i]), .tick(tick[i]), .sq(sq[i])
    );
  end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed traces of tick/sq/cfg_ready/cfg_err against hand-computed patterns
module tb_tick_gen;
  localparam int CNT_W = 8;
`ifdef TICK_GEN_SQ_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, sync = 1'b0;
  logic [2:0] tick, sq;
  logic [31:0] h_t0, h_t1, h_t2, h_s0, h_s1, h_s2, h_rdy, h_err;
  int n_cmp = 0, n_bad = 0;
  tick_gen_if #(.NUM_CH(3), .CNT_W(CNT_W)) cfg_if ();
  tick_gen #(.NUM_CH(3), .CNT_W(CNT_W), .DIV_INIT({8'd7, 8'd5, 8'd4})) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg(cfg_if),
    .tick(tick), .sq(sq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  // history bit 0 is the newest cycle; a trace of N cycles reads cycle 1 at bit N-1
  task automatic cyc();
    @(posedge clk);
    #1;
    h_t0  = {h_t0[30:0], tick[0]};
    h_t1  = {h_t1[30:0], tick[1]};
    h_t2  = {h_t2[30:0], tick[2]};
    h_s0  = {h_s0[30:0], sq[0]};
    h_s1  = {h_s1[30:0], sq[1]};
    h_s2  = {h_s2[30:0], sq[2]};
    h_rdy = {h_rdy[30:0], cfg_if.cfg_ready};
    h_err = {h_err[30:0], cfg_if.cfg_err};
  endtask
  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    sync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = 2'd0;
    cfg_if.cfg_div = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b1;
    {h_t0, h_t1, h_t2, h_s0, h_s1, h_s2, h_rdy, h_err} = '0;
  endtask
  initial begin
    do_reset();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg_if.cfg_err), 32'd0);
    for (int c = 1; c <= 14; c++) cyc();
    chk("run_t0", h_t0, 32'(14'b00010_00100_0100));
    chk("run_t1", h_t1, 32'(14'b00001_00001_0000));
    chk("run_t2", h_t2, 32'(14'b00000_01000_0001));
    chk("run_sq0", h_s0, SQ ? 32'(14'b00011_00110_0110) : 32'd0);
    chk("run_sq1", h_s1, SQ ? 32'(14'b00001_10001_1000) : 32'd0);
    chk("run_sq2", h_s2, SQ ? 32'(14'b00000_11100_0001) : 32'd0);
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 6) en = 1'b0;
      if (c == 9) en = 1'b1;
    end
    chk("pause_t0", h_t0, 32'(20'b00010_00000_10001_00010));
    chk("pause_t1", h_t1, 32'(20'b00001_00000_00100_00100));
    chk("pause_t2", h_t2, 32'(20'b00000_00001_00000_01000));
    chk("pause_sq1", h_s1, SQ ? 32'(20'b00001_11110_00110_00110) : 32'd0);
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd0;
        cfg_if.cfg_div = 8'd3;
      end
      if (c == 2) cfg_if.cfg_div = 8'd2;
      if (c == 5) cfg_if.cfg_valid = 1'b0;
    end
    chk("load_t0", h_t0, 32'(14'b00010_01010_1010));
    chk("load_ready", h_rdy, 32'(14'b10010_01111_1111));
    chk("load_err", h_err, 32'd0);
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd0;
        cfg_if.cfg_div = 8'd0;
      end
      if (c == 2 || c == 4) cfg_if.cfg_valid = 1'b0;
      if (c == 3) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd3;
        cfg_if.cfg_div = 8'd2;
      end
    end
    chk("rej_t0", h_t0, 32'(14'b00010_00100_0100));
    chk("rej_t2", h_t2, 32'(14'b00000_01000_0001));
    chk("rej_err", h_err, 32'(14'b01010_00000_0000));
    chk("rej_ready", h_rdy, 32'(14'b11111_11111_1111));
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (c == 2) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd2;
        cfg_if.cfg_div = 8'd3;
      end
      if (c == 3) cfg_if.cfg_valid = 1'b0;
      if (c == 4) sync = 1'b1;
      if (c == 5) sync = 1'b0;
    end
    chk("sync_t0", h_t0, 32'(16'b00010_00010_00100_0));
    chk("sync_t1", h_t1, 32'(16'b00000_00001_00001_0));
    chk("sync_t2", h_t2, 32'(16'b00000_00100_10010_0));
    chk("sync_sq0", h_s0, SQ ? 32'(16'b00010_00011_00110_0) : 32'd0);
    chk("sync_ready", h_rdy, 32'(16'b11001_11111_11111_1));
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd2;
        cfg_if.cfg_div = 8'd2;
      end
      if (c == 2) begin
        cfg_if.cfg_valid = 1'b0;
        reset = 1'b1;
      end
      if (c == 3) reset = 1'b0;
    end
    chk("mrst_t0", h_t0, 32'(14'b00000_01000_1000));
    chk("mrst_t2", h_t2, 32'(14'b00000_00001_0000));
    chk("mrst_ready", h_rdy, 32'(14'b10111_11111_1111));
    chk("mrst_err", h_err, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
